// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit for the EX stage.
// MULT/MULTU run a shift-add multiply and DIV/DIVU run a restoring divide.
// Each operation takes ITER iteration cycles, and the pipeline is stalled
// for that whole time. On completion the unit drives {hi_we, lo_we, hi, lo}
// for one cycle.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        cancel_i,
  output logic        stallreq_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [65:0] hilo_bus_o
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                accept, busy, last_iter, hilo_we;

  // Operand / working registers (data only, no reset)
  logic [2*DATA_W-1:0] mcand_r, acc_r, acc_nxt;
  logic [DATA_W-1:0]   mplier_r;
  logic [DATA_W-1:0]   quo_r, quo_nxt, dvs_r, rem_r, rem_nxt, a_raw_r;
  logic                neg_res_r, neg_rem_r, bzero_r;
  logic [DATA_W:0]     prem, trial;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic                is_signed;

  // Result registers, visible on the bus
  logic [DATA_W-1:0]   hi_r, lo_r;

  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic sgn);
    logic signed [DATA_W-1:0] n;
    n = -v;
    return (sgn && v[DATA_W-1]) ? DATA_W'(n) : DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg32(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] cond_neg64(input logic [2*DATA_W-1:0] v,
                                                     input logic neg);
    return neg ? (~v + (2*DATA_W)'(1)) : v;
  endfunction

  assign is_signed = ~op_i[0];
  assign abs_a     = abs_val(src_a_i, is_signed);
  assign abs_b     = abs_val(src_b_i, is_signed);
  assign busy      = (state == MUL) || (state == DIV);
  assign accept    = (state == IDLE) && start_i && !cancel_i;
  assign last_iter = busy && (cnt == CNT_LAST) && !cancel_i;

  // One multiply step and one restoring-divide step; the 33-bit partial
  // remainder carries its borrow in the top bit of the trial subtraction.
  always_comb begin
    acc_nxt = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    prem    = {rem_r, quo_r[DATA_W-1]};
    trial   = prem - {1'b0, dvs_r};
    if (!trial[DATA_W]) begin
      rem_nxt = trial[DATA_W-1:0];
      quo_nxt = {quo_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = prem[DATA_W-1:0];
      quo_nxt = {quo_r[DATA_W-2:0], 1'b0};
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a flush while iterating drops straight back to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = op_i[1] ? DIV : MUL;
      MUL, DIV: begin
        if (cancel_i)              state_nxt = IDLE;
        else if (cnt == CNT_LAST)  state_nxt = DONE;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Iteration counter: cleared on acceptance, advances every working cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     cnt <= '0;
    else if (accept) cnt <= '0;
    else if (busy)   cnt <= cnt + CNT_W'(1);
  end

  // Operand capture and iteration datapath; later operand changes are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      a_raw_r   <= src_a_i;
      mcand_r   <= {{DATA_W{1'b0}}, abs_a};
      mplier_r  <= abs_b;
      acc_r     <= '0;
      quo_r     <= abs_a;
      dvs_r     <= abs_b;
      rem_r     <= '0;
      neg_res_r <= is_signed && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
      neg_rem_r <= is_signed && src_a_i[DATA_W-1];
      bzero_r   <= (src_b_i == '0);
    end else if (state == MUL) begin
      acc_r    <= acc_nxt;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else if (state == DIV) begin
      quo_r <= quo_nxt;
      rem_r <= rem_nxt;
    end
  end

  // Result registers: sign-corrected on the final iteration, held afterwards
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (last_iter) begin
      if (state == MUL) begin
        {hi_r, lo_r} <= cond_neg64(acc_nxt, neg_res_r);
      end else if (bzero_r) begin
        hi_r <= a_raw_r;
        lo_r <= '1;
      end else begin
        hi_r <= cond_neg32(rem_nxt, neg_rem_r);
        lo_r <= cond_neg32(quo_nxt, neg_res_r);
      end
    end
  end

  assign hilo_we    = (state == DONE) && !cancel_i;
  assign stallreq_o = accept || (busy && !cancel_i);
  assign busy_o     = busy;
  assign done_o     = (state == DONE);
  assign hilo_bus_o = {hilo_we, hilo_we, hi_r, lo_r};

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit. Each issued operation
// pushes its expected result and completion cycle into a scoreboard; a
// monitor pops and compares whenever the unit presents a write on the bus.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        cancel_i;
  logic        stallreq_o;
  logic        busy_o;
  logic        done_o;
  logic [65:0] hilo_bus_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];

  muldiv_unit dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .op_i       (op_i),
    .src_a_i    (src_a_i),
    .src_b_i    (src_b_i),
    .cancel_i   (cancel_i),
    .stallreq_o (stallreq_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hilo_bus_o (hilo_bus_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: any write presented on the bus must match the oldest expectation
  always @(negedge clk) begin
    if (resetn && (done_o || hilo_bus_o[65] || hilo_bus_o[64])) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 66'({done_o, hilo_bus_o[65:64]}), 66'(0));
      end else begin
        logic [63:0] e;
        int          c;
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("hilo_bus",   hilo_bus_o,  {2'b11, e});
        check("done_cycle", 66'(cyc),    66'(c));
        check("done_o",     66'(done_o), 66'(1));
      end
    end
  end

  // Issue one operation, hold start until completion, scramble operands meanwhile
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int  stall_cnt;
    bit  seen;
    stall_cnt = 0;
    seen      = 0;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    exp_q.push_back({hi, lo});
    exp_cyc_q.push_back(cyc + 33);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stallreq_o) stall_cnt++;
      if (done_o) begin
        seen = 1;
        check("stall_in_done", 66'(stallreq_o), 66'(0));
        start_i = 1'b0;
        break;
      end
      if (i == 1) begin
        src_a_i = ~a;
        src_b_i = b ^ 32'h5a5a_a5a5;
      end
      @(negedge clk);
    end
    check("done_seen",    66'(seen),      66'(1));
    check("stall_cycles", 66'(stall_cnt), 66'(33));
    if (!seen) begin
      start_i = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b0;
    start_i  = 1'b0;
    cancel_i = 1'b0;
    op_i     = 2'b00;
    src_a_i  = '0;
    src_b_i  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  66'(busy_o),     66'(0));
    check("rst_done",  66'(done_o),     66'(0));
    check("rst_stall", 66'(stallreq_o), 66'(0));
    check("rst_bus",   hilo_bus_o,      66'(0));
    resetn = 1'b1;

    @(negedge clk);
    check("idle_stall", 66'(stallreq_o), 66'(0));

    // cancel in IDLE blocks acceptance
    start_i  = 1'b1;
    cancel_i = 1'b1;
    #1;
    check("idle_cancel_stall", 66'(stallreq_o), 66'(0));
    @(negedge clk);
    check("idle_cancel_busy", 66'(busy_o), 66'(0));
    start_i  = 1'b0;
    cancel_i = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(2'b11, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);

    // cancel a divide mid-flight: no write may appear afterwards
    @(negedge clk);
    start_i = 1'b1;
    op_i    = 2'b10;
    src_a_i = 32'd1000;
    src_b_i = 32'd3;
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    start_i  = 1'b0;
    #1;
    check("cancel_stall", 66'(stallreq_o), 66'(0));
    check("cancel_busy_before", 66'(busy_o), 66'(1));
    @(negedge clk);
    check("cancel_idle", 66'(busy_o), 66'(0));
    cancel_i = 1'b0;
    repeat (40) @(negedge clk);
    check("cancel_bus_held", hilo_bus_o, {2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF});

    run_op(2'b01, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
    repeat (3) @(negedge clk);
    check("result_held", hilo_bus_o, {2'b00, 32'h0, 32'h0000_000C});

    // asynchronous reset in the middle of a multiply
    start_i = 1'b1;
    op_i    = 2'b00;
    src_a_i = 32'd7;
    src_b_i = 32'd9;
    repeat (5) @(posedge clk);
    #3;
    resetn  = 1'b0;
    start_i = 1'b0;
    #1;
    check("areset_busy",  66'(busy_o),     66'(0));
    check("areset_stall", 66'(stallreq_o), 66'(0));
    check("areset_bus",   hilo_bus_o,      66'(0));
    check("areset_done",  66'(done_o),     66'(0));
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_busy", 66'(busy_o), 66'(0));
    check("post_reset_done", 66'(done_o), 66'(0));
    check("post_reset_bus",  hilo_bus_o,  66'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
